// File: rtl/jt12_cen_chain.sv
// Clock-enable generator: runtime-selectable prescaler followed by a cascade of
// integer dividers, all phase-aligned, with glitch-free setting changes and resync.
module jt12_cen_chain #(
    parameter int                  W           = 5,
    parameter int                  STAGES      = 3,
    parameter logic [W*STAGES-1:0] DIVS        = {5'd2, 5'd6, 5'd12},
    parameter int                  PRE0        = 6,
    parameter int                  PRE1        = 2,
    parameter int                  PRE2        = 6,
    parameter int                  PRE3        = 3,
    parameter logic [1:0]          DEF_SETTING = 2'd2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [1:0]        div_setting,
    input  logic              sync,
    output logic              cen_main,
    output logic [STAGES-1:0] cen_stage,
    output logic              pres_busy
);

    // Terminal counts (divisor - 1); divisors of 0 or 1 both give a count of 0
    localparam logic [W-1:0] LIM0 = (PRE0 <= 1) ? '0 : W'(PRE0 - 1);
    localparam logic [W-1:0] LIM1 = (PRE1 <= 1) ? '0 : W'(PRE1 - 1);
    localparam logic [W-1:0] LIM2 = (PRE2 <= 1) ? '0 : W'(PRE2 - 1);
    localparam logic [W-1:0] LIM3 = (PRE3 <= 1) ? '0 : W'(PRE3 - 1);

    logic [W-1:0] pres_cnt_reg;
    logic [W-1:0] pres_cnt_next;
    logic [W-1:0] pres_lim;
    logic [1:0]   act_sel_reg;
    logic [1:0]   act_sel_next;
    logic [1:0]   pend_sel_reg;
    logic [1:0]   pend_sel_next;
    logic         pend_vld_reg;
    logic         pend_vld_next;
    logic [1:0]   req_sel;
    logic [1:0]   base_sel;
    logic         tick;
    logic         pres_wrap;
    logic         change;

    always_comb begin
        case (act_sel_reg)
            2'd0:    pres_lim = LIM0;
            2'd1:    pres_lim = LIM1;
            2'd2:    pres_lim = LIM2;
            default: pres_lim = LIM3;
        endcase
    end

    // No pulse can escape while reset is held, even though counters sit at zero
    assign tick      = cen & ~sync & rst_n;
    assign pres_wrap = tick & (pres_cnt_reg >= pres_lim);
    assign cen_main  = tick & (pres_cnt_reg == '0);
    assign pres_busy = pend_vld_reg;

    assign req_sel  = pend_vld_reg ? pend_sel_reg : act_sel_reg;
    assign change   = (div_setting != req_sel);
    assign base_sel = (pres_wrap && pend_vld_reg) ? pend_sel_reg : act_sel_reg;

    always_comb begin
        act_sel_next  = act_sel_reg;
        pend_sel_next = pend_sel_reg;
        pend_vld_next = pend_vld_reg;
        pres_cnt_next = pres_cnt_reg;
        if (sync) begin
            // div_setting is either the outstanding request or a newer one
            act_sel_next  = div_setting;
            pend_sel_next = div_setting;
            pend_vld_next = 1'b0;
            pres_cnt_next = '0;
        end else begin
            act_sel_next = base_sel;
            if (pres_wrap) begin
                pend_vld_next = 1'b0;
            end
            if (change) begin
                pend_sel_next = div_setting;
                pend_vld_next = (div_setting != base_sel);
            end
            if (tick) begin
                pres_cnt_next = pres_wrap ? '0 : pres_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_cnt_reg <= '0;
            act_sel_reg  <= DEF_SETTING;
            pend_sel_reg <= DEF_SETTING;
            pend_vld_reg <= 1'b0;
        end else begin
            pres_cnt_reg <= pres_cnt_next;
            act_sel_reg  <= act_sel_next;
            pend_sel_reg <= pend_sel_next;
            pend_vld_reg <= pend_vld_next;
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam logic [W-1:0] DIV = DIVS[gi*W +: W];
            localparam logic [W-1:0] LIM = (DIV <= 1) ? '0 : DIV - 1'b1;

            logic [W-1:0] stg_cnt_reg;
            logic         stg_adv;

            if (gi == 0) begin : g_first
                assign stg_adv = cen_main;
            end else begin : g_next
                assign stg_adv = cen_stage[gi-1];
            end

            assign cen_stage[gi] = stg_adv & (stg_cnt_reg == '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stg_cnt_reg <= '0;
                end else if (sync) begin
                    stg_cnt_reg <= '0;
                end else if (stg_adv) begin
                    stg_cnt_reg <= (stg_cnt_reg >= LIM) ? '0 : stg_cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_jt12_cen_chain.sv
// Directed bench for jt12_cen_chain: pulse counts, first/second positions and
// gaps per output over scripted windows, compared with hand-derived values.
module tb_jt12_cen_chain;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic [1:0] div_setting = 2'd2;
    logic       sync = 1'b0;
    logic       cen_main;
    logic [2:0] cen_stage;
    logic       pres_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // index 0 = cen_main, 1..3 = cen_stage[0..2]
    int cnt [4];
    int first [4];
    int second [4];
    int gmin [4];
    int gmax [4];
    int last [4];
    int busy_cnt;
    int busy_first;
    int bad;
    int sync_hit;

    jt12_cen_chain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .div_setting (div_setting),
        .sync        (sync),
        .cen_main    (cen_main),
        .cen_stage   (cen_stage),
        .pres_busy   (pres_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        cen         = 1'b1;
        sync        = 1'b0;
        div_setting = 2'd2;
        @(negedge clk);
        check("rst_cen_main", int'(cen_main), 0);
        check("rst_cen_stage", int'(cen_stage), 0);
        check("rst_busy", int'(pres_busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // n cycles; tog: cen on even cycles only; ds0 then v1 from c1, v2 from c2; sync at sc
    task automatic run(input string tag, input int n, input bit tog, input logic [1:0] ds0,
                       input int c1, input logic [1:0] v1, input int c2, input logic [1:0] v2,
                       input int sc);
        logic [3:0] o;
        for (int k = 0; k < 4; k++) begin
            cnt[k] = 0; first[k] = -1; second[k] = -1;
            gmin[k] = 1000000; gmax[k] = -1; last[k] = -1;
        end
        busy_cnt = 0; busy_first = -1; bad = 0; sync_hit = 0;
        for (int i = 0; i < n; i++) begin
            cen = tog ? (i % 2 == 0) : 1'b1;
            div_setting = ds0;
            if (c1 >= 0 && i >= c1) div_setting = v1;
            if (c2 >= 0 && i >= c2) div_setting = v2;
            sync = (i == sc);
            @(negedge clk);
            o = {cen_stage, cen_main};
            if (!cen && o != 4'd0) bad++;
            if (sync && o != 4'd0) sync_hit++;
            if (pres_busy) begin
                if (busy_first < 0) busy_first = i;
                busy_cnt++;
            end
            for (int k = 0; k < 4; k++) begin
                if (o[k]) begin
                    if (cnt[k] == 0) first[k] = i;
                    if (cnt[k] == 1) second[k] = i;
                    if (last[k] >= 0) begin
                        if (i - last[k] < gmin[k]) gmin[k] = i - last[k];
                        if (i - last[k] > gmax[k]) gmax[k] = i - last[k];
                    end
                    last[k] = i;
                    cnt[k]++;
                end
            end
            @(posedge clk);
            #1;
        end
        sync = 1'b0;
        $display("run %s: main=%0d s0=%0d s1=%0d s2=%0d busy=%0d", tag,
                 cnt[0], cnt[1], cnt[2], cnt[3], busy_cnt);
    endtask

    initial begin
        // defaults, cen always high: periods 6 / 72 / 432 / 864
        do_reset();
        run("defaults", 900, 1'b0, 2'd2, -1, 2'd0, -1, 2'd0, -1);
        check("t1_main_cnt", cnt[0], 150);
        check("t1_main_first", first[0], 0);
        check("t1_main_gmin", gmin[0], 6);
        check("t1_main_gmax", gmax[0], 6);
        check("t1_s0_cnt", cnt[1], 13);
        check("t1_s0_first", first[1], 0);
        check("t1_s0_gap", gmax[1], 72);
        check("t1_s0_gmin", gmin[1], 72);
        check("t1_s1_cnt", cnt[2], 3);
        check("t1_s1_gap", gmin[2], 432);
        check("t1_s2_cnt", cnt[3], 2);
        check("t1_s2_first", first[3], 0);
        check("t1_s2_gap", gmax[3], 864);
        check("t1_busy", busy_cnt, 0);

        // cen 1-of-2: cen_main every 12 clk, stage 0 every 144
        do_reset();
        run("cen_toggle", 300, 1'b1, 2'd2, -1, 2'd0, -1, 2'd0, -1);
        check("t2_main_cnt", cnt[0], 25);
        check("t2_main_gmin", gmin[0], 12);
        check("t2_main_gmax", gmax[0], 12);
        check("t2_s0_cnt", cnt[1], 3);
        check("t2_s0_gap", gmin[1], 144);
        check("t2_no_pulse_cen0", bad, 0);

        // 2->3 one clk after a pulse: old period completes, stage counter keeps phase
        do_reset();
        run("switch_2_3", 80, 1'b0, 2'd2, 1, 2'd3, -1, 2'd0, -1);
        check("t3_busy_cnt", busy_cnt, 4);
        check("t3_busy_first", busy_first, 2);
        check("t3_main_cnt", cnt[0], 26);
        check("t3_main_second", second[0], 6);
        check("t3_main_gmin", gmin[0], 3);
        check("t3_main_gmax", gmax[0], 6);
        check("t3_s0_cnt", cnt[1], 3);
        check("t3_s0_second", second[1], 39);
        check("t3_s0_gmin", gmin[1], 36);

        // 2->3->1 before the wrap: only setting 1 is applied
        do_reset();
        run("switch_2_3_1", 16, 1'b0, 2'd2, 1, 2'd3, 2, 2'd1, -1);
        check("t4a_busy_cnt", busy_cnt, 4);
        check("t4a_main_cnt", cnt[0], 6);
        check("t4a_main_second", second[0], 6);
        check("t4a_main_gmin", gmin[0], 2);

        // 2->3->2 before the wrap: pending cancelled at once
        do_reset();
        run("switch_2_3_2", 16, 1'b0, 2'd2, 1, 2'd3, 2, 2'd2, -1);
        check("t4b_busy_cnt", busy_cnt, 1);
        check("t4b_busy_first", busy_first, 2);
        check("t4b_main_cnt", cnt[0], 3);
        check("t4b_main_gmin", gmin[0], 6);

        // sync at pres_cnt=3, stg_cnt0=5 (cycle 27): everything fires at 28
        do_reset();
        run("sync_mid", 110, 1'b0, 2'd2, -1, 2'd0, -1, 2'd0, 27);
        check("t5_sync_quiet", sync_hit, 0);
        check("t5_main_cnt", cnt[0], 19);
        check("t5_main_gmin", gmin[0], 4);
        check("t5_s0_second", second[1], 28);
        check("t5_s0_gmax", gmax[1], 72);
        check("t5_s1_second", second[2], 28);
        check("t5_s2_second", second[3], 28);

        // sync on a would-be pulse cycle together with 2->3: applied directly
        do_reset();
        run("sync_change", 16, 1'b0, 2'd2, 6, 2'd3, -1, 2'd0, 6);
        check("t6_sync_quiet", sync_hit, 0);
        check("t6_busy_cnt", busy_cnt, 0);
        check("t6_main_cnt", cnt[0], 4);
        check("t6_main_second", second[0], 7);
        check("t6_main_gmin", gmin[0], 3);
        check("t6_s0_second", second[1], 7);

        // async reset mid-period with a change pending
        do_reset();
        run("pre_reset", 3, 1'b0, 2'd2, 1, 2'd3, -1, 2'd0, -1);
        check("t7_busy_before", int'(pres_busy), 1);
        cen   = 1'b1;
        rst_n = 1'b0;
        #2;
        check("t7_main_in_reset", int'(cen_main), 0);
        check("t7_stage_in_reset", int'(cen_stage), 0);
        check("t7_busy_in_reset", int'(pres_busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run("post_reset", 16, 1'b0, 2'd2, -1, 2'd0, -1, 2'd0, -1);
        check("t7_main_cnt", cnt[0], 3);
        check("t7_main_gmin", gmin[0], 6);
        check("t7_busy_cnt", busy_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
